// File: rtl/muldiv_ctrl_if.sv
// EX-stage multiply/divide request bus: operands and MT writes in, stall/done/HI/LO out.
interface muldiv_ctrl_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             mthi;
   logic             mtlo;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   // EX stage / hazard side
   modport master (
      output start, op, a, b, mthi, mtlo, flush,
      input  busy, done, hi, lo
   );

   // Controller side
   modport slave (
      input  start, op, a, b, mthi, mtlo, flush,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, 32 CALC cycles plus one FIX cycle.
// Optional divide datapath is built only when MULDIV_DIV_EN is defined.
module muldiv_ctrl #(
   parameter int unsigned WIDTH = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   muldiv_ctrl_if.slave   bus
);

   localparam int unsigned AW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] ma_q, ma_d;
   logic [WIDTH-1:0] mb_q, mb_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

`ifdef MULDIV_DIV_EN
   logic             is_div_q, is_div_d;
   logic             rneg_q, rneg_d;
   logic             div0_q, div0_d;
   logic [WIDTH-1:0] araw_q, araw_d;
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;
`endif

   logic             sgn;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic             accept;
   logic [CW-1:0]    idx;
   logic [AW-1:0]    res;

   // Operand magnitudes; op[0] clear selects the signed variants
   assign sgn   = ~bus.op[0];
   assign a_neg = sgn & bus.a[WIDTH-1];
   assign b_neg = sgn & bus.b[WIDTH-1];
   assign abs_a = a_neg ? -bus.a : bus.a;
   assign abs_b = b_neg ? -bus.b : bus.b;

`ifdef MULDIV_DIV_EN
   assign accept = bus.start & ~bus.flush;
`else
   assign accept = bus.start & ~bus.flush & ~bus.op[1];
`endif

   // Next-state, datapath step and HI/LO update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      ma_d    = ma_q;
      mb_d    = mb_q;
      neg_d   = neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      res     = '0;
      idx     = CW'(WIDTH - 1) - cnt_q;
`ifdef MULDIV_DIV_EN
      is_div_d = is_div_q;
      rneg_d   = rneg_q;
      div0_d   = div0_q;
      araw_d   = araw_q;
      trial    = '0;
      diff     = '0;
`endif

      case (state_q)
         IDLE: begin
            if (bus.mthi) hi_d = bus.a;
            if (bus.mtlo) lo_d = bus.a;
            if (accept) begin
               state_d = CALC;
               cnt_d   = '0;
               acc_d   = '0;
               ma_d    = abs_a;
               mb_d    = abs_b;
               neg_d   = a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
               is_div_d = bus.op[1];
               rneg_d   = a_neg;
               div0_d   = (bus.b == '0);
               araw_d   = bus.a;
`endif
            end
         end

         CALC: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
`ifdef MULDIV_DIV_EN
            if (is_div_q) begin
               // Restoring step: remainder in the upper half, quotient shifts into the lower half
               trial = {acc_q[AW-1:WIDTH], ma_q[idx]};
               if (trial >= {1'b0, mb_q}) begin
                  diff  = trial - {1'b0, mb_q};
                  acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
               end
            end else
`endif
            begin
               // MSB-first shift-add over the multiplier magnitude
               acc_d = {acc_q[AW-2:0], 1'b0} + (mb_q[idx] ? {{WIDTH{1'b0}}, ma_q} : '0);
            end
         end

         FIX: begin
            state_d = IDLE;
`ifdef MULDIV_DIV_EN
            if (is_div_q) begin
               if (div0_q) begin
                  lo_d = '1;
                  hi_d = araw_q;
               end else begin
                  lo_d = neg_q  ? -acc_q[WIDTH-1:0]  : acc_q[WIDTH-1:0];
                  hi_d = rneg_q ? -acc_q[AW-1:WIDTH] : acc_q[AW-1:WIDTH];
               end
            end else
`endif
            begin
               res  = neg_q ? -acc_q : acc_q;
               hi_d = res[AW-1:WIDTH];
               lo_d = res[WIDTH-1:0];
            end
         end

         default: state_d = IDLE;
      endcase

      // Abort wins over everything, including a same-cycle MT write or result write
      if (bus.flush) begin
         state_d = IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end

      busy_d = (state_d != IDLE);
      done_d = (state_d == FIX);
   end

   // State, datapath and architectural registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         ma_q    <= '0;
         mb_q    <= '0;
         neg_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
         is_div_q <= 1'b0;
         rneg_q   <= 1'b0;
         div0_q   <= 1'b0;
         araw_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         ma_q    <= ma_d;
         mb_q    <= mb_d;
         neg_q   <= neg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef MULDIV_DIV_EN
         is_div_q <= is_div_d;
         rneg_q   <= rneg_d;
         div0_q   <= div0_d;
         araw_q   <= araw_d;
`endif
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule
